// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: serialises one read/write frame per accepted
// request and returns a single-cycle response. The pad tristate lives in the parent.
module mdio_master #(
  parameter int CLK_DIV = 20,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_vld,
  output logic        req_ack,
  input  logic        req_wr,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdat,
  output logic        rsp_vld,
  output logic [15:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int N     = PRE_LEN + 32;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit, w_nxt_bit;
  logic              r_mdc, r_mdio_o, r_mdio_oe, r_wr, r_err;
  logic              r_rsp_vld, r_rsp_err;
  logic [15:0]       r_rdat, r_rsp_dat;
  logic [N-2:0]      r_frame;
  logic [N-1:0]      w_frame_load;
  logic              w_accept, w_framing, w_wrap, w_rise, w_bit_end, w_last;

  // Handshake: a request transfers in the cycle req_vld && req_ack; req_ack is
  // high only in IDLE, so requests presented while a frame runs are ignored.
  assign w_accept  = req_vld && (r_state == S_IDLE);
  assign w_framing = r_state inside {S_PRE, S_HDR, S_TA, S_DATA};
  assign w_wrap    = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise    = w_framing && w_wrap && !r_mdc;
  assign w_bit_end = w_framing && w_wrap && r_mdc;
  assign w_last    = (r_bit == BIT_W'(N - 1));
  assign w_nxt_bit = r_bit + BIT_W'(1);

  // Read frames carry ones in TA/DATA; the pad is released there anyway.
  assign w_frame_load = {{PRE_LEN{1'b1}}, 2'b01, (req_wr ? 2'b01 : 2'b10),
                         req_phy, req_reg, (req_wr ? 2'b10 : 2'b11),
                         (req_wr ? req_wdat : 16'hFFFF)};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_vld) w_state_nxt = S_PRE;
      S_PRE, S_HDR, S_TA, S_DATA: begin
        if (w_bit_end) begin
          if (w_last)                                  w_state_nxt = S_DONE;
          else if (w_nxt_bit < BIT_W'(PRE_LEN))        w_state_nxt = S_PRE;
          else if (w_nxt_bit < BIT_W'(PRE_LEN + 14))   w_state_nxt = S_HDR;
          else if (w_nxt_bit < BIT_W'(PRE_LEN + 16))   w_state_nxt = S_TA;
          else                                         w_state_nxt = S_DATA;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_mdc     <= 1'b0;
      r_mdio_o  <= 1'b1;
      r_mdio_oe <= 1'b0;
      r_frame   <= '1;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_rdat    <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rsp_vld <= 1'b0;
      if (w_accept) begin
        r_div     <= '0;
        r_bit     <= '0;
        r_mdc     <= 1'b0;
        r_frame   <= w_frame_load[N-2:0];
        r_mdio_o  <= w_frame_load[N-1];
        r_mdio_oe <= 1'b1;
        r_wr      <= req_wr;
        r_err     <= 1'b0;
        r_rdat    <= '0;
      end else if (w_framing) begin
        if (w_wrap) begin
          r_div <= '0;
          r_mdc <= !r_mdc;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
        // mdio_i is captured on the cycle where mdc goes high.
        if (w_rise && (r_state == S_TA) && (r_bit == BIT_W'(PRE_LEN + 15)))
          r_err <= mdio_i;
        if (w_rise && (r_state == S_DATA))
          r_rdat <= {r_rdat[14:0], mdio_i};
        if (w_bit_end) begin
          if (w_last) begin
            r_mdio_o  <= 1'b1;
            r_mdio_oe <= 1'b0;
            r_rsp_vld <= 1'b1;
            r_rsp_dat <= r_wr ? 16'h0000 : r_rdat;
            r_rsp_err <= !r_wr && r_err;
          end else begin
            r_bit     <= w_nxt_bit;
            r_frame   <= {r_frame[N-3:0], 1'b1};
            r_mdio_o  <= r_frame[N-2];
            r_mdio_oe <= r_wr || (w_nxt_bit < BIT_W'(PRE_LEN + 14));
          end
        end
      end
    end
  end

  assign req_ack = w_accept;
  assign rsp_vld = r_rsp_vld;
  assign rsp_dat = r_rsp_dat;
  assign rsp_err = r_rsp_err;
  assign busy    = w_framing;
  assign mdc     = r_mdc;
  assign mdio_o  = r_mdio_o;
  assign mdio_oe = r_mdio_oe;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: per-cycle comparison against a timing model of the
// MDIO frame, a PHY responder, directed scenarios and a CLK_DIV=20 instance.
module tb_mdio_master;

  localparam int D   = 2;
  localparam int PRE = 32;
  localparam int N   = 64;
  localparam int BP  = 2 * D;
  localparam int FR  = N * BP;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req_vld = 0, req_wr = 0, mdio_i = 1;
  logic [4:0]  req_phy = 0, req_reg = 0;
  logic [15:0] req_wdat = 0;
  logic        req_ack, rsp_vld, rsp_err, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_dat;

  logic        b_req_vld = 0, b_req_wr = 0, b_mdio_i = 1;
  logic [4:0]  b_req_phy = 0, b_req_reg = 0;
  logic [15:0] b_req_wdat = 0;
  logic        b_req_ack, b_rsp_vld, b_rsp_err, b_busy, b_mdc, b_mdio_o, b_mdio_oe;
  logic [15:0] b_rsp_dat;

  mdio_master #(.CLK_DIV(D), .PRE_LEN(PRE)) u_dut (
    .clk(clk), .rstn(rstn), .req_vld(req_vld), .req_ack(req_ack),
    .req_wr(req_wr), .req_phy(req_phy), .req_reg(req_reg), .req_wdat(req_wdat),
    .rsp_vld(rsp_vld), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(20), .PRE_LEN(32)) u_d20 (
    .clk(clk), .rstn(rstn), .req_vld(b_req_vld), .req_ack(b_req_ack),
    .req_wr(b_req_wr), .req_phy(b_req_phy), .req_reg(b_req_reg), .req_wdat(b_req_wdat),
    .rsp_vld(b_rsp_vld), .rsp_dat(b_rsp_dat), .rsp_err(b_rsp_err), .busy(b_busy),
    .mdc(b_mdc), .mdio_o(b_mdio_o), .mdio_oe(b_mdio_oe), .mdio_i(b_mdio_i)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: current frame, held response, and observations for literal checks.
  bit          on = 0, m_active = 0;
  int          cyc = 0, m_acc = 0, m_acc_cnt = 0, dut_rsp_cnt = 0, last_rsp_rel = 0;
  logic [63:0] m_bits, cap;
  logic        m_wr, m_ta2, m_err = 0, prev_mdc = 0;
  logic [15:0] m_rdat, m_dat = 0;
  logic        p_ta2 = 0;
  logic [15:0] p_rdat = 0;

  function automatic logic [63:0] frame_bits(input logic wr, input logic [4:0] phy,
                                             input logic [4:0] rg, input logic [15:0] wd);
    logic [31:0] tail;
    tail[31:30] = 2'b01;
    tail[29:28] = wr ? 2'b01 : 2'b10;
    tail[27:23] = phy;
    tail[22:18] = rg;
    tail[17:16] = wr ? 2'b10 : 2'b00;
    tail[15:0]  = wr ? wd : 16'h0000;
    return {32'hFFFF_FFFF, tail};
  endfunction

  initial begin
    int rel, k, ph;
    logic e_ack, e_vld, e_busy, e_mdc, e_oe, e_o;
    wait (on);
    forever begin
      @(negedge clk);
      cyc++;
      rel = cyc - m_acc;
      e_vld = 0; e_busy = 0; e_mdc = 0; e_oe = 0; e_o = 1; k = -1;
      if (m_active && rel >= 1 && rel <= FR) begin
        k = (rel - 1) / BP;
        ph = (rel - 1) % BP;
        e_busy = 1;
        e_mdc = (ph >= D);
        e_oe = m_wr || (k < PRE + 14);
        e_o = m_bits[63-k];
      end else if (m_active && rel == FR + 1) begin
        e_vld = 1;
        m_dat = m_wr ? 16'h0000 : m_rdat;
        m_err = m_wr ? 1'b0 : m_ta2;
      end
      e_ack = req_vld && !(m_active && rel <= FR + 1);
      chk("ctl_ack_vld_busy_mdc_oe", {req_ack, rsp_vld, busy, mdc, mdio_oe},
          {e_ack, e_vld, e_busy, e_mdc, e_oe});
      if (e_oe) chk("mdio_o", mdio_o, e_o);
      chk("rsp_err_dat", {rsp_err, rsp_dat}, {m_err, m_dat});
      if (mdc && !prev_mdc) cap = {cap[62:0], mdio_o};
      prev_mdc = mdc;
      if (rsp_vld) begin
        dut_rsp_cnt++;
        last_rsp_rel = rel;
      end
      // PHY responder drives each read bit for its whole bit period.
      mdio_i = 1'b1;
      if (m_active && !m_wr && k == PRE + 15) mdio_i = m_ta2;
      else if (m_active && !m_wr && k >= PRE + 16) mdio_i = m_rdat[15-(k-PRE-16)];
      if (m_active && rel == FR + 1) m_active = 0;
      if (!rstn) begin
        m_active = 0;
        m_dat = 0;
        m_err = 0;
      end else if (e_ack) begin
        m_active = 1;
        m_acc = cyc;
        m_bits = frame_bits(req_wr, req_phy, req_reg, req_wdat);
        m_wr = req_wr;
        m_ta2 = p_ta2;
        m_rdat = p_rdat;
        cap = '0;
        m_acc_cnt++;
      end
    end
  end

  task automatic send(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                      input logic [15:0] wd, input logic ta2, input logic [15:0] rd,
                      input bit hold);
    int c0, t;
    c0 = m_acc_cnt;
    req_wr = wr; req_phy = phy; req_reg = rg; req_wdat = wd;
    p_ta2 = ta2; p_rdat = rd;
    req_vld = 1;
    t = 0;
    while (m_acc_cnt == c0 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_timeout", (m_acc_cnt == c0), 0);
    if (!hold) begin
      req_vld = 0;
      req_phy = 5'($urandom); req_reg = 5'($urandom); req_wdat = 16'($urandom);
      req_wr = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_active && t < 600) begin
      @(posedge clk); #1;
      if ((cyc + 1 - m_acc) < FR) begin
        req_vld = 1'($urandom_range(0, 1));
        req_phy = 5'($urandom);
        req_wdat = 16'($urandom);
      end else begin
        req_vld = 0;
      end
      t++;
    end
    req_vld = 0;
    chk("idle_timeout", m_active, 0);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input logic ta2, input logic [15:0] rd);
    send(wr, phy, rg, wd, ta2, rd, 0);
    wait_idle();
  endtask

  task automatic run_d20();
    logic [15:0] rd;
    int k, rsp_rel;
    logic e_mdc;
    rd = 16'($urandom);
    rsp_rel = -1;
    @(posedge clk); #1;
    b_req_wr = 0; b_req_phy = 5'd3; b_req_reg = 5'd1; b_req_vld = 1;
    @(negedge clk);
    chk("d20_ack", b_req_ack, 1);
    for (int rel = 1; rel <= 2570; rel++) begin
      @(negedge clk);
      b_req_vld = 0;
      k = (rel - 1) / 40;
      e_mdc = (rel <= 2560) && (((rel - 1) % 40) >= 20);
      chk("d20_mdc", b_mdc, e_mdc);
      chk("d20_busy_oe", {b_busy, b_mdio_oe}, {(rel <= 2560), (rel <= 2560 && k < 46)});
      if (b_rsp_vld) rsp_rel = rel;
      b_mdio_i = 1'b1;
      if (k == 47) b_mdio_i = 1'b0;
      else if (k >= 48 && k < 64) b_mdio_i = rd[15-(k-48)];
    end
    chk("d20_rsp_cycle", rsp_rel, 2561);
    chk("d20_rsp", {b_rsp_err, b_rsp_dat}, {1'b0, rd});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, c;
    logic wr, ta2;
    logic [15:0] rd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {req_ack, rsp_vld, rsp_err, busy, mdc, mdio_o, mdio_oe},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("reset_rsp_dat", rsp_dat, 0);
    @(posedge clk); #1;
    rstn = 1;
    on = 1;
    repeat (2) @(posedge clk);
    #1;

    // Directed write from the example frame.
    run_frame(1, 5'd1, 5'd0, 16'h1140, 0, 0);
    chk("t1_stream", cap, 64'hFFFF_FFFF_5082_1140);
    chk("t1_rsp_cycle", last_rsp_rel, 257);
    chk("t1_rsp", {rsp_err, rsp_dat}, 17'h0);

    // Read with a responding PHY.
    c = dut_rsp_cnt;
    run_frame(0, 5'd1, 5'd2, 16'h0, 0, 16'h0022);
    chk("t2_rsp", {rsp_err, rsp_dat}, {1'b0, 16'h0022});
    chk("t2_rsp_count", dut_rsp_cnt - c, 1);

    // Read with no PHY: line floats high.
    run_frame(0, 5'd4, 5'd1, 16'h0, 1, 16'hFFFF);
    chk("t3_rsp", {rsp_err, rsp_dat}, {1'b1, 16'hFFFF});

    // Back-to-back: write then read queued with req_vld held.
    send(1, 5'd5, 5'd9, 16'hA5C3, 0, 0, 1);
    a0 = m_acc;
    send(0, 5'd6, 5'd3, 16'h0, 0, 16'h5A3C, 0);
    chk("t4_second_ack_gap", m_acc - a0, 258);
    wait_idle();
    chk("t4_rsp", {rsp_err, rsp_dat}, {1'b0, 16'h5A3C});

    // Reset pulse at the start of bit 40 of a write.
    c = dut_rsp_cnt;
    send(1, 5'($urandom), 5'($urandom), 16'($urandom), 0, 0, 0);
    a0 = 0;
    while ((cyc + 1 - m_acc) != 1 + 40 * BP && a0 < 400) begin
      @(posedge clk); #1;
      a0++;
    end
    chk("t5_wait_timeout", (a0 >= 400), 0);
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    chk("t5_after_reset", {req_ack, rsp_vld, rsp_err, busy, mdc, mdio_o, mdio_oe},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("t5_after_reset_dat", rsp_dat, 0);
    repeat (300) @(posedge clk);
    #1;
    chk("t5_no_rsp", dut_rsp_cnt - c, 0);
    run_frame(1, 5'd2, 5'd7, 16'($urandom), 0, 0);
    chk("t5_full_preamble", cap[63:32], 32'hFFFF_FFFF);

    // Randomised frames.
    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom);
      ta2 = ($urandom_range(0, 3) == 0);
      rd = 16'($urandom);
      run_frame(wr, 5'($urandom), 5'($urandom), 16'($urandom), ta2, rd);
      chk("rand_rsp", {rsp_err, rsp_dat}, wr ? 17'h0 : {ta2, rd});
    end

    run_d20();

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
